// File: rtl/exc_vector_seq_pkg.sv
// rtl/exc_vector_seq_pkg.sv - shared CPU constants for the exception vector sequencer
package exc_vector_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_FETCH = 2'd2,
    ST_LOAD  = 2'd3
  } exc_state_e;

  // Memory-address mux select codes, shared with the main control unit
  localparam logic [2:0] SEL_PC   = 3'b000;
  localparam logic [2:0] SEL_V253 = 3'b100;
  localparam logic [2:0] SEL_V254 = 3'b101;
  localparam logic [2:0] SEL_V255 = 3'b110;

  // Exception cause codes
  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] CAUSE_OVF    = 2'b10;
  localparam logic [1:0] CAUSE_DIV0   = 2'b11;

  // Fixed priority: invalid opcode, then overflow, then divide-by-zero
  function automatic logic [1:0] prio_cause(input logic opc, input logic ovf, input logic div0);
    if (opc)       return CAUSE_OPCODE;
    else if (ovf)  return CAUSE_OVF;
    else if (div0) return CAUSE_DIV0;
    else           return CAUSE_NONE;
  endfunction

  // Each cause owns one vector byte near the top of memory
  function automatic logic [2:0] cause_to_sel(input logic [1:0] c);
    case (c)
      CAUSE_OPCODE: return SEL_V253;
      CAUSE_OVF:    return SEL_V254;
      CAUSE_DIV0:   return SEL_V255;
      default:      return SEL_PC;
    endcase
  endfunction

endpackage

// File: rtl/exc_vector_seq_if.sv
// rtl/exc_vector_seq_if.sv - request/response bundle between CPU datapath and exception sequencer
interface exc_vector_seq_if #(
  parameter int W = 32
);
  logic         exc_opcode;
  logic         exc_ovf;
  logic         exc_div0;
  logic [W-1:0] pc_in;
  logic [W-1:0] mem_data;
  logic         busy;
  logic         sel_override;
  logic [2:0]   mem_addr_sel;
  logic         epc_wr;
  logic [W-1:0] epc_out;
  logic         pc_wr;
  logic [W-1:0] pc_new;
  logic [1:0]   cause;
  logic         exc_lost;

  // CPU side: raises requests and supplies PC / memory data
  modport master (
    output exc_opcode, exc_ovf, exc_div0, pc_in, mem_data,
    input  busy, sel_override, mem_addr_sel, epc_wr, epc_out, pc_wr, pc_new, cause, exc_lost
  );

  // Sequencer side
  modport slave (
    input  exc_opcode, exc_ovf, exc_div0, pc_in, mem_data,
    output busy, sel_override, mem_addr_sel, epc_wr, epc_out, pc_wr, pc_new, cause, exc_lost
  );
endinterface

// File: rtl/exc_vector_seq.sv
// rtl/exc_vector_seq.sv - saves EPC, fetches the handler vector byte and loads PC on an exception
module exc_vector_seq
  import exc_vector_seq_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  exc_vector_seq_if.slave  bus
);

  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  exc_state_e   state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [1:0]   cause_q, cause_d;
  logic [W-1:0] pc_q, pc_d;
  logic         lost_q, lost_d;
  logic         any_req;

  logic         busy_c, ovr_c, epc_wr_c, pc_wr_c;
  logic [2:0]   sel_c;
  logic [W-1:0] epc_out_c, pc_new_c;

  logic         unused_mem_hi;
  assign unused_mem_hi = ^bus.mem_data[W-1:8];

  assign any_req = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;

  // State, latency counter, latched cause/PC and sticky loss flag
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      cause_q <= CAUSE_NONE;
      pc_q    <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      pc_q    <= pc_d;
      lost_q  <= lost_d;
    end
  end

  // Sequencing: latch on entry, count memory latency in FETCH, flag requests seen while busy
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    pc_d    = pc_q;
    lost_d  = lost_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_SAVE;
          cause_d = prio_cause(bus.exc_opcode, bus.exc_ovf, bus.exc_div0);
          pc_d    = bus.pc_in;
        end
      end
      ST_SAVE: begin
        state_d = ST_FETCH;
        cnt_d   = LAT_LOAD;
      end
      ST_FETCH: begin
        if (cnt_q == 3'd0) state_d = ST_LOAD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_LOAD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_q != ST_IDLE && any_req) lost_d = 1'b1;
  end

  // Outputs decoded from state and latched registers only; requests never reach them directly
  always_comb begin
    busy_c    = 1'b0;
    ovr_c     = 1'b0;
    sel_c     = SEL_PC;
    epc_wr_c  = 1'b0;
    epc_out_c = '0;
    pc_wr_c   = 1'b0;
    pc_new_c  = '0;
    case (state_q)
      ST_SAVE: begin
        busy_c    = 1'b1;
        epc_wr_c  = 1'b1;
        epc_out_c = pc_q - W'(4);
      end
      ST_FETCH: begin
        busy_c = 1'b1;
        ovr_c  = 1'b1;
        sel_c  = cause_to_sel(cause_q);
      end
      ST_LOAD: begin
        busy_c   = 1'b1;
        ovr_c    = 1'b1;
        sel_c    = cause_to_sel(cause_q);
        pc_wr_c  = 1'b1;
        pc_new_c = {{(W-8){1'b0}}, bus.mem_data[7:0]};
      end
      default: ;
    endcase
  end

  assign bus.busy         = busy_c;
  assign bus.sel_override = ovr_c;
  assign bus.mem_addr_sel = sel_c;
  assign bus.epc_wr       = epc_wr_c;
  assign bus.epc_out      = epc_out_c;
  assign bus.pc_wr        = pc_wr_c;
  assign bus.pc_new       = pc_new_c;
  assign bus.cause        = cause_q;
  assign bus.exc_lost     = lost_q;

endmodule

// File: doc/exc_vector_seq.md
# exc_vector_seq

Exception vector sequencer for the multicycle CPU. On an exception request it saves the faulting instruction address into EPC. It then takes over the memory-address mux select to fetch the handler byte from fixed vector location 253, 254 or 255, and loads PC with that byte zero-extended. While active it stalls the main control unit, and it releases the mux select when finished.

## Interface
Parameters:
- `MEM_LAT`, 2: cycles from address presentation to valid `mem_data`; legal range 1..7.
- `W`, 32: datapath width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `exc_opcode`  in  1  invalid-opcode exception request; level, sampled in IDLE.
- `exc_ovf`  in  1  ALU overflow exception request.
- `exc_div0`  in  1  divide-by-zero exception request.
- `pc_in`  in  W  current PC register; already incremented past the faulting instruction.
- `mem_data`  in  W  memory read data; only bits [7:0] are used.
- `busy`  out  1  sequence active; main control holds its state.
- `sel_override`  out  1  top level uses `mem_addr_sel` instead of the main control select.
- `mem_addr_sel`  out  3  memory-address mux select: 100 = 253, 101 = 254, 110 = 255, otherwise 000.
- `epc_wr`  out  1  EPC register write enable.
- `epc_out`  out  W  EPC write data.
- `pc_wr`  out  1  PC write enable.
- `pc_new`  out  W  PC write data.
- `cause`  out  2  latched cause: 01 opcode, 10 overflow, 11 div0, 00 none.
- `exc_lost`  out  1  sticky flag: a request arrived while busy.

## Operation
- States: IDLE, SAVE, FETCH, LOAD.
- IDLE → SAVE when any request is high.
  - Priority on simultaneous requests: opcode > overflow > div0.
  - Latch `cause` and `pc_in`.
- SAVE, 1 cycle:
  - `epc_wr`=1.
  - `epc_out` = latched PC − 4, modulo 2^W; PC 0 wraps to 0xFFFFFFFC.
- FETCH:
  - Drive `mem_addr_sel` from `cause`: 01→100, 10→101, 11→110.
  - `sel_override`=1.
  - 3-bit down-counter loaded with MEM_LAT−1; leave when it reaches 0, so FETCH lasts exactly MEM_LAT cycles.
- LOAD, 1 cycle:
  - `sel_override` and `mem_addr_sel` stay asserted.
  - `pc_wr`=1, `pc_new` = {24'b0, mem_data[7:0]}.
  - Next state IDLE.
- `busy`=1 in SAVE, FETCH and LOAD.
- Requests arriving while not in IDLE are dropped and set `exc_lost`. Only reset clears `exc_lost`.
- A request still high on return to IDLE starts a new sequence. Callers must deassert requests once `busy` is seen.
- `cause` holds its value after the sequence ends, until the next exception.
- Outside their active states, `epc_wr` and `pc_wr` are 0, and `epc_out` and `pc_new` are 0.

## Timing
- Reset (`reset_n`=0 at a rising edge) forces: state IDLE, counter 0, all outputs 0, `mem_addr_sel`=000, `cause`=00, `exc_lost`=0.
- Reset mid-sequence aborts at that edge; no further `epc_wr` or `pc_wr` pulses.
- Request high at edge N gives SAVE during cycle N+1.
- FETCH spans cycles N+2 .. N+1+MEM_LAT.
- LOAD is cycle N+2+MEM_LAT; PC updates at the end of that cycle.
- IDLE at N+3+MEM_LAT.
- Total busy = MEM_LAT+2 cycles.
- `mem_data` is sampled only in LOAD.
- All outputs are registered or decoded from state only; there is no combinational path from request inputs to outputs.

## Structure
- Shared CPU package holds:
  - state encoding constants;
  - mux select codes SEL_PC=000, SEL_V253=100, SEL_V254=101, SEL_V255=110;
  - cause codes.
  The main control unit uses the same select constants.
- Single module; the latency counter is inline and needs no sub-module.
- The top level instantiates this block beside the main control. A 2:1 select mux driven by `sel_override` feeds the memory-address mux.

## Test plan
- MEM_LAT=2. `exc_ovf` pulse with `pc_in`=0x00000040 → `epc_wr` with `epc_out`=0x3C one cycle later. `mem_addr_sel`=101 for 2 cycles. `mem_data`=0xABCD12F7 → `pc_wr` with `pc_new`=0x000000F7. `busy` high 4 cycles.
- All three requests high together → `cause`=01, `mem_addr_sel`=100.
- `exc_div0` asserted while in FETCH of an opcode sequence → `exc_lost`=1; sequence completes with `cause`=01; `exc_lost` stays 1.
- `reset_n` low during FETCH → next cycle IDLE, all outputs 0, `pc_wr` never pulses.
- `pc_in`=0 with `exc_opcode` → `epc_out`=0xFFFFFFFC.
- MEM_LAT=1 and MEM_LAT=7 → FETCH lasts exactly 1 and 7 cycles; `pc_new` equals the low byte of `mem_data` sampled in LOAD.
